// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scan driver: segment decode table,
// the "all segments off" pattern and the digit-index width helper.
package sevenseg_pkg;

    typedef logic [6:0] seg_t;

    // Active-high {a,b,c,d,e,f,g}; listed from nibble 15 down to nibble 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
        7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
        7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
        7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
    };

    localparam seg_t SEG_OFF = 7'b0000000;

    function automatic int unsigned idx_width(input int unsigned digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/sevenseg_scan_driver_if.sv
// Bundle between the datapath, the scan driver and the display pins.
// The datapath side uses modport master; the driver uses modport slave.
interface sevenseg_scan_driver_if #(
    parameter int unsigned DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   blank_in;
    logic                load;
    logic                load_ack;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   an;
    logic                frame_start;

    modport master (
        output value,
        output dp_in,
        output blank_in,
        output load,
        input  load_ack,
        input  seg,
        input  dp,
        input  an,
        input  frame_start
    );

    modport slave (
        input  value,
        input  dp_in,
        input  blank_in,
        input  load,
        output load_ack,
        output seg,
        output dp,
        output an,
        output frame_start
    );

endinterface

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-high seven-segment pattern.
module hex_to_seg
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed seven-segment driver with frame-synchronous data update.
// Optional feature macro: LEADING_ZERO_BLANK_EN (auto-blank leading zero digits).
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned PRESCALE       = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input logic                   clk,
    input logic                   rst_n,
    sevenseg_scan_driver_if.slave bus
);

    localparam int unsigned IdxW = idx_width(DIGITS);
    localparam int unsigned CntW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    localparam seg_t              SegOffPin = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic              DpOffPin  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [DIGITS-1:0] AnOffPin  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CntW-1:0]     cnt_q;
    logic [IdxW-1:0]     idx_q;

    logic [4*DIGITS-1:0] pend_value_q;
    logic [DIGITS-1:0]   pend_dp_q;
    logic [DIGITS-1:0]   pend_blank_q;
    logic                pend_flag_q;

    logic [4*DIGITS-1:0] act_value_q;
    logic [DIGITS-1:0]   act_dp_q;
    logic [DIGITS-1:0]   act_blank_q;

    logic                swap_q;
    logic                load_ack_q;
    logic                frame_start_q;
    seg_t                seg_q;
    logic                dp_q;
    logic [DIGITS-1:0]   an_q;

    logic                tick;
    logic                last_digit;
    logic                boundary;
    logic                commit;

    logic [3:0]          sel_nibble;
    logic                sel_dp;
    logic                sel_blank;
    logic                sel_lz;
    logic [DIGITS-1:0]   lz_mask;
    logic [DIGITS-1:0]   an_hi;
    seg_t                dec_seg;
    seg_t                seg_hi;
    logic                dp_hi;
    seg_t                seg_pin_d;
    logic                dp_pin_d;
    logic [DIGITS-1:0]   an_pin_d;

    assign tick       = (cnt_q == CntW'(PRESCALE - 1));
    assign last_digit = (idx_q == IdxW'(DIGITS - 1));
    assign boundary   = tick && last_digit;
    // A load landing on the boundary cycle is applied directly, not deferred a frame.
    assign commit     = boundary && (pend_flag_q || bus.load);

`ifdef LEADING_ZERO_BLANK_EN
    logic upper_zero;

    always_comb begin
        lz_mask    = '0;
        upper_zero = 1'b1;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            upper_zero = upper_zero && (act_value_q[4*i +: 4] == 4'h0);
            lz_mask[i] = upper_zero;
        end
    end
`else
    assign lz_mask = '0;
`endif

    always_comb begin
        sel_nibble = 4'h0;
        sel_dp     = 1'b0;
        sel_blank  = 1'b0;
        sel_lz     = 1'b0;
        an_hi      = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IdxW'(i)) begin
                sel_nibble = act_value_q[4*i +: 4];
                sel_dp     = act_dp_q[i];
                sel_blank  = act_blank_q[i];
                sel_lz     = lz_mask[i];
                an_hi[i]   = 1'b1;
            end
        end
    end

    hex_to_seg u_hex_to_seg (
        .nibble (sel_nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        seg_hi    = (sel_blank || sel_lz) ? SEG_OFF : dec_seg;
        dp_hi     = !sel_blank && sel_dp;
        seg_pin_d = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
        dp_pin_d  = SEG_ACTIVE_LOW ? ~dp_hi : dp_hi;
        an_pin_d  = AN_ACTIVE_LOW ? ~an_hi : an_hi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            pend_value_q  <= '0;
            pend_dp_q     <= '0;
            pend_blank_q  <= '0;
            pend_flag_q   <= 1'b0;
            act_value_q   <= '0;
            act_dp_q      <= '0;
            act_blank_q   <= '1;
            swap_q        <= 1'b0;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
            seg_q         <= SegOffPin;
            dp_q          <= DpOffPin;
            an_q          <= AnOffPin;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
                idx_q <= last_digit ? '0 : idx_q + 1'b1;
            end

            if (bus.load) begin
                pend_value_q <= bus.value;
                pend_dp_q    <= bus.dp_in;
                pend_blank_q <= bus.blank_in;
            end

            if (commit) begin
                act_value_q <= bus.load ? bus.value    : pend_value_q;
                act_dp_q    <= bus.load ? bus.dp_in    : pend_dp_q;
                act_blank_q <= bus.load ? bus.blank_in : pend_blank_q;
                pend_flag_q <= 1'b0;
            end else if (bus.load) begin
                pend_flag_q <= 1'b1;
            end

            // Ack trails the swap by one cycle so it lines up with digit 0 at the pins.
            swap_q        <= commit;
            load_ack_q    <= swap_q;
            frame_start_q <= (idx_q == '0) && (cnt_q == '0);
            seg_q         <= seg_pin_d;
            dp_q          <= dp_pin_d;
            an_q          <= an_pin_d;
        end
    end

    assign bus.load_ack    = load_ack_q;
    assign bus.frame_start = frame_start_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.an          = an_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed self-checking bench for sevenseg_scan_driver (DIGITS=4, PRESCALE=4, active-low pins).
module tb_sevenseg_scan_driver;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned PRESCALE = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int k     = 0;
    int acks  = 0;
    int acks0 = 0;

    sevenseg_scan_driver_if #(.DIGITS(DIGITS)) bus ();

    sevenseg_scan_driver #(
        .DIGITS         (DIGITS),
        .PRESCALE       (PRESCALE),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // k = index of the output cycle visible now; k=0 is the first cycle after reset release.
    task automatic step();
        @(negedge clk);
        k++;
        if (bus.load_ack === 1'b1) acks++;
    endtask

    task automatic step_to(input int target);
        while (k < target) step();
    endtask

    task automatic expect_digit(input string tag, input int d, input logic [6:0] seg_hi,
                                input logic dp_hi);
        logic [3:0] an_exp;
        logic [6:0] seg_exp;
        logic       dp_exp;
        an_exp  = ~(4'b0001 << d);
        seg_exp = ~seg_hi;
        dp_exp  = ~dp_hi;
        check({tag, "/an"}, 16'(bus.an), 16'(an_exp));
        check({tag, "/seg"}, 16'(bus.seg), 16'(seg_exp));
        check({tag, "/dp"}, 16'(bus.dp), 16'(dp_exp));
    endtask

    task automatic expect_off(input string tag);
        check({tag, "/seg"}, 16'(bus.seg), 16'h007f);
        check({tag, "/dp"}, 16'(bus.dp), 16'h0001);
        check({tag, "/an"}, 16'(bus.an), 16'h000f);
        check({tag, "/ack"}, 16'(bus.load_ack), 16'h0000);
        check({tag, "/fs"}, 16'(bus.frame_start), 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] an_exp;
        bus.value    = '0;
        bus.dp_in    = '0;
        bus.blank_in = '0;
        bus.load     = 1'b0;

        repeat (3) @(negedge clk);
        expect_off("reset");

        k     = -1;
        rst_n = 1'b1;

        // Idle: dark digits scanning, frame_start every 16 cycles.
        for (int i = 0; i < 40; i++) begin
            step();
            an_exp = ~(4'b0001 << ((k / 4) % 4));
            check("idle/an", 16'(bus.an), 16'(an_exp));
            check("idle/seg", 16'(bus.seg), 16'h007f);
            check("idle/fs", 16'(bus.frame_start), 16'((k % 16) == 0));
        end

        // Mid-frame load, applied at the next boundary.
        step_to(41);
        bus.value = 16'h1A2F;
        bus.dp_in = 4'b0100;
        bus.load  = 1'b1;
        step();
        bus.load = 1'b0;
        bus.dp_in = '0;
        acks0 = acks;
        step_to(47);
        check("mid/still_dark", 16'(bus.seg), 16'h007f);
        check("mid/no_ack_yet", 16'(bus.load_ack), 16'h0000);
        step();
        check("mid/ack", 16'(bus.load_ack), 16'h0001);
        check("mid/fs", 16'(bus.frame_start), 16'h0001);
        expect_digit("mid/d0", 0, 7'b1000111, 1'b0);
        step();
        check("mid/ack_one_cycle", 16'(bus.load_ack), 16'h0000);
        step_to(52);
        expect_digit("mid/d1", 1, 7'b1101101, 1'b0);
        step_to(56);
        expect_digit("mid/d2", 2, 7'b1110111, 1'b1);
        step_to(60);
        expect_digit("mid/d3", 3, 7'b0110000, 1'b0);
        step_to(63);
        check("mid/ack_count", 16'(acks - acks0), 16'h0001);

        // Two loads in one frame: latest wins, single ack.
        step_to(65);
        bus.value = 16'h1111;
        bus.load  = 1'b1;
        step();
        bus.load = 1'b0;
        acks0 = acks;
        step_to(69);
        bus.value = 16'h2222;
        bus.load  = 1'b1;
        step();
        bus.load = 1'b0;
        step_to(79);
        check("dbl/no_ack_yet", 16'(acks - acks0), 16'h0000);
        step();
        check("dbl/ack", 16'(bus.load_ack), 16'h0001);
        expect_digit("dbl/d0", 0, 7'b1101101, 1'b0);
        step_to(92);
        expect_digit("dbl/d3", 3, 7'b1101101, 1'b0);
        step_to(94);
        check("dbl/ack_count", 16'(acks - acks0), 16'h0001);

        // Load on the exact boundary cycle.
        bus.value = 16'h3456;
        bus.load  = 1'b1;
        step();
        bus.load = 1'b0;
        acks0 = acks;
        step();
        check("bnd/ack", 16'(bus.load_ack), 16'h0001);
        expect_digit("bnd/d0", 0, 7'b1011111, 1'b0);
        step_to(100);
        expect_digit("bnd/d1", 1, 7'b1011011, 1'b0);
        step_to(104);
        expect_digit("bnd/d2", 2, 7'b0110011, 1'b0);
        step_to(108);
        expect_digit("bnd/d3", 3, 7'b1111001, 1'b0);
        step_to(112);
        check("bnd/ack_count", 16'(acks - acks0), 16'h0001);

        // Leading zeros, with a dp on the most significant digit.
        step_to(113);
        bus.value = 16'h0050;
        bus.dp_in = 4'b1000;
        bus.load  = 1'b1;
        step();
        bus.load  = 1'b0;
        bus.dp_in = '0;
        step_to(128);
        expect_digit("lz/d0", 0, 7'b1111110, 1'b0);
        step_to(132);
        expect_digit("lz/d1", 1, 7'b1011011, 1'b0);
`ifdef LEADING_ZERO_BLANK_EN
        step_to(136);
        expect_digit("lz/d2", 2, 7'b0000000, 1'b0);
        step_to(140);
        expect_digit("lz/d3", 3, 7'b0000000, 1'b1);
`else
        step_to(136);
        expect_digit("lz/d2", 2, 7'b1111110, 1'b0);
        step_to(140);
        expect_digit("lz/d3", 3, 7'b1111110, 1'b1);
`endif

        // Explicit blanking suppresses dp but keeps an active.
        step_to(145);
        bus.value    = 16'h8888;
        bus.dp_in    = 4'b0011;
        bus.blank_in = 4'b0010;
        bus.load     = 1'b1;
        step();
        bus.load     = 1'b0;
        bus.dp_in    = '0;
        bus.blank_in = '0;
        step_to(160);
        expect_digit("blk/d0", 0, 7'b1111111, 1'b1);
        step_to(164);
        expect_digit("blk/d1", 1, 7'b0000000, 1'b0);

        // Reset while a load is pending: lost, no ack, display dark.
        step_to(177);
        bus.value = 16'hABCD;
        bus.load  = 1'b1;
        step();
        bus.load = 1'b0;
        step_to(185);
        expect_digit("pre_rst/d2", 2, 7'b1111111, 1'b0);
        rst_n = 1'b0;
        #1;
        expect_off("rst_mid");
        repeat (2) @(negedge clk);
        k     = -1;
        rst_n = 1'b1;
        acks0 = acks;
        step();
        check("rel/fs", 16'(bus.frame_start), 16'h0001);
        expect_digit("rel/d0", 0, 7'b0000000, 1'b0);
        for (int i = 0; i < 39; i++) begin
            step();
            check("rel/dark", 16'(bus.seg), 16'h007f);
        end
        check("rel/no_ack", 16'(acks - acks0), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
